jtag_csr_bridge: RTL and testbench
==================================

# jtag_csr_bridge

- Downstream consumer of the ECP5 JTAGG user-register (ER1) signals.
- Implements a wide ER1 data register carrying {data, addr, write} commands. On Update-DR it issues one request/acknowledge transaction on a simple CSR bus.
- The read result and status are returned on the next Capture-DR.
- Everything runs in the jtck domain, between the JTAGG primitive and the on-chip CSR fabric.

## Interface

Parameters:
- ADDR_W, 8, CSR address width.
- DATA_W, 32, CSR data width.
- TIMEOUT, 255, jtck cycles to wait for bus_ack before aborting; 0 disables the timeout.

Ports:
- jtck  in  1  JTAGG JTCK. The only clock.
- jrst  in  1  Synchronous, active-high reset.
- jtdi  in  1  JTAGG JTDI. Lags jshift by one jtck.
- jshift  in  1  JTAGG JSHIFT (Shift-DR).
- jupdate  in  1  JTAGG JUPDATE (Update-DR).
- jce1  in  1  JTAGG JCE1. High in Capture-DR/Shift-DR when ER1 is selected.
- jtdo1  out  1  JTAGG JTDO1. Serial DR output.
- bus_req  out  1  Transaction request. Held until ack or timeout.
- bus_we  out  1  1 = write, 0 = read. Stable while bus_req is high.
- bus_addr  out  ADDR_W  Stable while bus_req is high.
- bus_wdata  out  DATA_W  Stable while bus_req is high.
- bus_ack  in  1  Completion. Sampled only while bus_req is high.
- bus_rdata  in  DATA_W  Valid in the bus_ack cycle.
- ovr  out  1  Sticky: a command was dropped because busy. Cleared only by jrst.

## Operation

- The DR length is L = 1 + ADDR_W + DATA_W and is shifted LSB first.
  - Command layout: bit 0 = write, bits [ADDR_W:1] = addr, bits [L-1:ADDR_W+1] = data.
  - Capture layout: bit 0 = busy, bit 1 = timeout flag of the last transaction, bits [ADDR_W:2] = 0, bits [L-1:ADDR_W+1] = rdata_hold.
- Internal registers:
  - sr[L-1:0]: shift register.
  - jshift_q: jshift delayed one cycle.
  - jce1_q: jce1 delayed one cycle.
  - sel: ER1 selected flag.
  - rdata_hold, to_flag, state, timeout counter.
- Capture: the cycle with jce1 && !jce1_q && !jshift loads sr with the capture layout and sets sel = 1.
- Shift: on every cycle with jshift_q && sel, sr <= {jtdi, sr[L-1:1]}. This includes the cycle after jshift falls, which delivers the last bit.
- jtdo1 = sel ? sr[0] : 0. It is combinational from sr.
- Update: the cycle with jupdate && sel clears sel.
  - If state == IDLE: latch sr fields into bus_we/bus_addr/bus_wdata, clear to_flag, go to REQ.
  - Otherwise the command is dropped and ovr is set.
- Updates while sel == 0 (another instruction was active) are ignored entirely.
- FSM:
  - IDLE: bus_req = 0. The timeout counter is cleared.
  - REQ: bus_req = 1, and the counter increments each cycle.
    - On bus_ack: rdata_hold <= bus_rdata if !bus_we (unchanged on writes), then go to IDLE.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ack: rdata_hold <= all ones, to_flag <= 1, go to IDLE.
- busy = (state == REQ).
- Simultaneous events:
  - Ack and update in the same cycle: busy is still 1, so the command is dropped and ovr is set.
  - Ack and capture in the same cycle: sr gets the pre-ack rdata_hold and busy = 1.
  - Capture and update cannot coincide (TAP sequence).
- Reset mid-transaction: bus_req drops in the cycle after jrst is sampled; there is no completion.

## Timing

- Reset values: jtdo1 = 0, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, ovr = 0, sel = 0, sr = 0, rdata_hold = 0, to_flag = 0, state = IDLE.
- Update to bus_req high: 1 jtck (registered).
- bus_ack to bus_req low: 1 jtck. bus_req never re-asserts in the cycle it falls.
- Minimum transaction: bus_req is high for 1 cycle when ack is returned combinationally.
- Timeout: bus_req is high for exactly TIMEOUT cycles.
- Read data is visible only via the next Capture-DR. The host must not rely on it until busy reads 0.

## Test plan

- Reset with jrst = 1 for 2 cycles: all outputs 0, and capture returns bit0 = 0 and data 0.
- Write with ADDR_W = 8, DATA_W = 32: shift the command {0xDEADBEEF, 0x12, 1} and update.
  - bus_req rises 1 cycle after jupdate with bus_we = 1, bus_addr = 0x12, bus_wdata = 0xDEADBEEF.
  - Ack after 3 cycles: bus_req falls the next cycle.
- Read of addr 0x34: bus_rdata = 0xCAFEF00D on ack. The next capture shifts out 0xCAFEF00D in the upper 32 bits, with bit0 = 0 and bit1 = 0.
- Timeout with TIMEOUT = 4 and no ack: bus_req is high for exactly 4 cycles. The next capture returns data 0xFFFFFFFF with bit1 = 1.
- Second update while busy: the command is dropped, ovr = 1 and stays 1. bus_addr is unchanged. A capture during REQ shows bit0 = 1.
- jupdate pulse without a preceding jce1 capture: no bus_req and no ovr. jrst asserted during REQ: bus_req = 0 the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/jtag_csr_bridge.sv
// rtl/jtag_csr_bridge.sv - ECP5 JTAGG ER1 data register bridged to a request/ack CSR bus
module jtag_csr_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              jtck,
    input  logic              jrst,
    input  logic              jtdi,
    input  logic              jshift,
    input  logic              jupdate,
    input  logic              jce1,
    output logic              jtdo1,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              ovr
);

    // DR length: {data, addr, write}
    localparam int L = 1 + ADDR_W + DATA_W;

    // Counter only has to reach TIMEOUT-1
    localparam int                CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state;
    logic [L-1:0]       sr;
    logic               jshift_q;
    logic               jce1_q;
    logic               sel;
    logic [DATA_W-1:0]  rdata_hold;
    logic               to_flag;
    logic [CNT_W-1:0]   cnt;

    logic               busy;
    logic               capture;
    logic               update;
    logic [L-1:0]       cap_word;

    assign busy     = (state == REQ);
    // Capture-DR is the first cycle of jce1 with shift still low
    assign capture  = jce1 && !jce1_q && !jshift;
    // Update only counts if ER1 was the register that went through capture
    assign update   = jupdate && sel;
    assign cap_word = {rdata_hold, {(ADDR_W-1){1'b0}}, to_flag, busy};

    assign jtdo1    = sel ? sr[0] : 1'b0;

    // Data register: capture, LSB-first shift (jtdi lags jshift by one cycle), select tracking
    always_ff @(posedge jtck) begin
        if (jrst) begin
            sr       <= '0;
            jshift_q <= 1'b0;
            jce1_q   <= 1'b0;
            sel      <= 1'b0;
        end else begin
            jshift_q <= jshift;
            jce1_q   <= jce1;
            if (capture) begin
                sr  <= cap_word;
                sel <= 1'b1;
            end else begin
                if (jshift_q && sel) begin
                    sr <= {jtdi, sr[L-1:1]};
                end
                if (update) begin
                    sel <= 1'b0;
                end
            end
        end
    end

    // Bus FSM: launch on update, finish on ack or timeout, flag commands dropped while busy
    always_ff @(posedge jtck) begin
        if (jrst) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            rdata_hold <= '0;
            to_flag    <= 1'b0;
            ovr        <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (update) begin
                        bus_we    <= sr[0];
                        bus_addr  <= sr[ADDR_W:1];
                        bus_wdata <= sr[L-1:ADDR_W+1];
                        to_flag   <= 1'b0;
                        bus_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    // An update landing on the ack cycle still sees busy and is dropped
                    if (update) begin
                        ovr <= 1'b1;
                    end
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rdata_hold <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end else if (TO_EN && (cnt == TO_LAST)) begin
                        rdata_hold <= '1;
                        to_flag    <= 1'b1;
                        bus_req    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    bus_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_csr_bridge.sv
// tb/tb_jtag_csr_bridge.sv - scoreboard bench for jtag_csr_bridge
module tb_jtag_csr_bridge;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int L       = 1 + ADDR_W + DATA_W;

    logic              jtck;
    logic              jrst;
    logic              jtdi;
    logic              jshift;
    logic              jupdate;
    logic              jce1;
    logic              jtdo1;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              ovr;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                len;
    } txn_t;

    txn_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int ack_delay = -1;
    logic [DATA_W-1:0] slave_rdata = '0;

    jtag_csr_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .jtck     (jtck),
        .jrst     (jrst),
        .jtdi     (jtdi),
        .jshift   (jshift),
        .jupdate  (jupdate),
        .jce1     (jce1),
        .jtdo1    (jtdo1),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .ovr      (ovr)
    );

    initial jtck = 1'b0;
    always #5 jtck = ~jtck;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [L-1:0] cmd_word(input logic [DATA_W-1:0] d,
                                              input logic [ADDR_W-1:0] a, input logic we);
        return {d, a, we};
    endfunction

    function automatic logic [L-1:0] cap_word(input logic [DATA_W-1:0] d,
                                              input logic to, input logic busy);
        return {d, {(ADDR_W-1){1'b0}}, to, busy};
    endfunction

    task automatic push_exp(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int len);
        txn_t t;
        t.we    = we;
        t.addr  = a;
        t.wdata = d;
        t.len   = len;
        exp_q.push_back(t);
    endtask

    // Capture, shift nsh bits LSB first (0 = straight to Exit1), optional Update
    task automatic scan_dr(input logic [L-1:0] din, input int nsh, input bit upd,
                           output logic [L-1:0] dout);
        dout   = '0;
        jce1   = 1'b1;
        jshift = 1'b0;
        jtdi   = 1'b0;
        @(negedge jtck);
        if (nsh > 0) begin
            jshift = 1'b1;
            @(negedge jtck);
            for (int i = 0; i < nsh; i++) begin
                dout[i] = jtdo1;
                jtdi    = din[i];
                if (i == nsh - 1) begin
                    jshift = 1'b0;
                    jce1   = 1'b0;
                end
                @(negedge jtck);
            end
        end else begin
            dout[0] = jtdo1;
            jce1    = 1'b0;
            @(negedge jtck);
        end
        jtdi    = 1'b0;
        jupdate = upd;
        @(negedge jtck);
        jupdate = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (bus_req && n < max) begin
            @(negedge jtck);
            n++;
        end
        if (bus_req) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: bus_req still 1 after %0d cycles, required 0", max);
        end
    endtask

    // Bus slave: acks in request cycle ack_delay (0 = same cycle), never if negative
    initial begin
        int req_cyc;
        req_cyc   = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge jtck);
            if (bus_req) begin
                bus_ack   = (ack_delay >= 0) && (req_cyc == ack_delay);
                bus_rdata = bus_ack ? slave_rdata : '0;
                req_cyc++;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = '0;
                req_cyc   = 0;
            end
        end
    end

    // Monitor: each bus_req burst pops one expected transaction
    initial begin
        txn_t cur;
        int   len;
        bit   active;
        bit   stable;
        active = 0;
        len    = 0;
        stable = 1;
        forever begin
            @(negedge jtck);
            if (bus_req) begin
                if (!active) begin
                    active = 1;
                    len    = 0;
                    stable = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h, required no request", bus_addr);
                        cur.we    = bus_we;
                        cur.addr  = bus_addr;
                        cur.wdata = bus_wdata;
                        cur.len   = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        check("req_we", 64'(bus_we), 64'(cur.we));
                        check("req_addr", 64'(bus_addr), 64'(cur.addr));
                        check("req_wdata", 64'(bus_wdata), 64'(cur.wdata));
                    end
                end else if (bus_we !== cur.we || bus_addr !== cur.addr || bus_wdata !== cur.wdata) begin
                    stable = 0;
                end
                len++;
            end else if (active) begin
                active = 0;
                check("req_stable", 64'(stable), 64'd1);
                if (cur.len >= 0) begin
                    check("req_len", 64'(len), 64'(cur.len));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [L-1:0] dout;
        jrst    = 1'b1;
        jtdi    = 1'b0;
        jshift  = 1'b0;
        jupdate = 1'b0;
        jce1    = 1'b0;
        repeat (2) @(negedge jtck);
        check("rst_jtdo1", 64'(jtdo1), 64'd0);
        check("rst_req", 64'(bus_req), 64'd0);
        check("rst_we", 64'(bus_we), 64'd0);
        check("rst_addr", 64'(bus_addr), 64'd0);
        check("rst_wdata", 64'(bus_wdata), 64'd0);
        check("rst_ovr", 64'(ovr), 64'd0);
        jrst = 1'b0;

        // Update without a prior ER1 capture
        jupdate = 1'b1;
        @(negedge jtck);
        jupdate = 1'b0;
        repeat (3) begin
            @(negedge jtck);
            check("stray_req", 64'(bus_req), 64'd0);
        end
        check("stray_ovr", 64'(ovr), 64'd0);

        scan_dr('0, L, 1'b0, dout);
        check("rst_cap", 64'(dout), 64'(cap_word('0, 1'b0, 1'b0)));

        // Write, ack in third request cycle
        ack_delay   = 2;
        slave_rdata = 32'h13579BDF;
        push_exp(1'b1, 8'h12, 32'hDEADBEEF, 3);
        scan_dr(cmd_word(32'hDEADBEEF, 8'h12, 1'b1), L, 1'b1, dout);
        check("wr_req_rise", 64'(bus_req), 64'd1);
        wait_idle(20);
        scan_dr('0, L, 1'b0, dout);
        check("wr_cap", 64'(dout), 64'(cap_word('0, 1'b0, 1'b0)));

        // Read with same-cycle ack
        ack_delay   = 0;
        slave_rdata = 32'hCAFEF00D;
        push_exp(1'b0, 8'h34, 32'h0, 1);
        scan_dr(cmd_word(32'h0, 8'h34, 1'b0), L, 1'b1, dout);
        wait_idle(20);
        scan_dr('0, L, 1'b0, dout);
        check("rd_cap", 64'(dout), 64'(cap_word(32'hCAFEF00D, 1'b0, 1'b0)));

        // Timeout
        ack_delay = -1;
        push_exp(1'b1, 8'h56, 32'h11223344, TIMEOUT);
        scan_dr(cmd_word(32'h11223344, 8'h56, 1'b1), L, 1'b1, dout);
        wait_idle(20);
        scan_dr('0, L, 1'b0, dout);
        check("to_cap", 64'(dout), 64'(cap_word(32'hFFFFFFFF, 1'b1, 1'b0)));

        // Second update while busy
        push_exp(1'b0, 8'h78, 32'h0, TIMEOUT);
        scan_dr(cmd_word(32'h0, 8'h78, 1'b0), L, 1'b1, dout);
        scan_dr(cmd_word(32'hAAAAAAAA, 8'h99, 1'b1), 0, 1'b1, dout);
        check("busy_cap_bit0", 64'(dout[0]), 64'd1);
        check("ovr_set", 64'(ovr), 64'd1);
        check("ovr_addr_kept", 64'(bus_addr), 64'h78);
        wait_idle(20);
        repeat (2) @(negedge jtck);
        check("ovr_sticky", 64'(ovr), 64'd1);

        // Accepted command clears the timeout flag
        ack_delay   = 1;
        slave_rdata = 32'h0BADCAFE;
        push_exp(1'b0, 8'h9A, 32'h0, 2);
        scan_dr(cmd_word(32'h0, 8'h9A, 1'b0), L, 1'b1, dout);
        wait_idle(20);
        scan_dr('0, L, 1'b0, dout);
        check("rd2_cap", 64'(dout), 64'(cap_word(32'h0BADCAFE, 1'b0, 1'b0)));
        check("ovr_sticky2", 64'(ovr), 64'd1);

        // Reset during REQ
        ack_delay = -1;
        push_exp(1'b1, 8'hAB, 32'h5A5A5A5A, 2);
        scan_dr(cmd_word(32'h5A5A5A5A, 8'hAB, 1'b1), L, 1'b1, dout);
        @(negedge jtck);
        jrst = 1'b1;
        @(negedge jtck);
        check("rst_req_drop", 64'(bus_req), 64'd0);
        check("rst_ovr_clr", 64'(ovr), 64'd0);
        jrst = 1'b0;
        scan_dr('0, L, 1'b0, dout);
        check("rst_idle_cap", 64'(dout), 64'(cap_word('0, 1'b0, 1'b0)));

        repeat (3) @(negedge jtck);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
